spike_aer_encoder: RTL

Downstream consumer of the neuron array's registered spike vector: on each computation-cycle tick it snapshots the spike vector and serialises every set bit into an address-event (AER) word {neuron index, timestamp}. Events go through a show-ahead FIFO with a valid/ready output handshake. The block isolates spike readout (host link, logger, next layer) from neuron-update timing. Drops and missed ticks are counted and flagged.

---
 rtl/spike_aer_encoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/spike_aer_encoder.sv
// Spike-vector to address-event encoder: snapshots the spike vector on each tick,
// serialises the set bits into {index, timestamp} words and buffers them in a show-ahead FIFO.
module spike_aer_encoder #(
    parameter int Nn    = 4,
    parameter int IDX_W = 2,
    parameter int TS_W  = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     tick,
    input  logic [Nn-1:0]            spikearray,
    input  logic                     clear_flags,
    output logic                     aer_valid,
    output logic [IDX_W+TS_W-1:0]    aer_data,
    input  logic                     aer_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     tick_miss,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = IDX_W + TS_W;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [Nn-1:0]      snap;
    logic [TS_W-1:0]    frame_ts;
    logic [TS_W-1:0]    ts;
    logic               start;
    logic               push_req;

    logic [EW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               full, pop, push_ok, drop;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        start     = 1'b0;
        push_req  = 1'b0;
        case (state)
            IDLE: begin
                if (tick && enable) begin
                    start     = 1'b1;
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                // Disabling mid-frame abandons the rest of the snapshot without pushing.
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    push_req = snap[idx];
                    if (idx == IDX_W'(Nn - 1)) state_nxt = IDLE;
                    else                       idx_nxt   = idx + IDX_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            snap     <= '0;
            frame_ts <= '0;
            ts       <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (start) begin
                snap     <= spikearray;
                frame_ts <= ts;
            end
            if (tick && enable) ts <= ts + TS_W'(1);
        end
    end

    assign full    = (count == CW'(DEPTH));
    assign pop     = (count != '0) && aer_ready;
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    // NOTE: the event storage is deliberately not reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {idx, frame_ts};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Set events take priority over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            tick_miss  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop)             overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;

            if (tick && enable && state == SCAN) tick_miss <= 1'b1;
            else if (clear_flags)                tick_miss <= 1'b0;

            if (drop) begin
                if (clear_flags)                drop_count <= 8'd1;
                else if (drop_count != 8'hFF)   drop_count <= drop_count + 8'd1;
            end else if (clear_flags) begin
                drop_count <= '0;
            end
        end
    end

    assign aer_valid  = (count != '0);
    assign aer_data   = aer_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

endmodule
